// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch/hold stage between the instruction RAM port and the
// controller. Owns the program counter, a one-word fetch buffer and the
// instruction register (IR). It decodes the IR into opcode and register
// fields, and keeps status flags plus a saturating retired-instruction count.
//
// Ports:
//   Clk            in   clock; all state updates on the rising edge
//   Reset          in   synchronous, active-high reset (overrides all strobes)
//   PC_Clr         in   clear PC to 0; also clears Halted and PC_Wrap
//   PC_Load        in   jump: PC <= zero-extended Dest_Reg of the current IR
//   PC_Inc         in   PC <= PC + 1 (mod 2^ADDR_WIDTH); bumps Inst_Count
//   IR_Load        in   copy the fetch buffer into the IR
//   Ram_Inst_Read  in   capture Ram_Inst_In into the fetch buffer
//   Ram_Inst_In    in   instruction word read from RAM at PC_Out
//   PC_Out         out  current PC (RAM instruction address)
//   Opcode         out  IR[15:12]
//   Dest_Reg       out  IR[11:8]
//   Source_Reg1    out  IR[7:4]
//   Source_Reg2    out  IR[3:0]
//   Illegal_Op     out  IR holds an opcode above MUL (7)
//   Halted         out  IR holds DONE (0)
//   PC_Wrap        out  sticky: an increment took the PC from all-ones to 0
//   Inst_Count     out  saturating count of cycles with PC_Inc asserted
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int OPCODE_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int INST_WIDTH     = OPCODE_WIDTH + 3 * REG_ADDR_WIDTH
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      PC_Clr,
  input  logic                      PC_Load,
  input  logic                      PC_Inc,
  input  logic                      IR_Load,
  input  logic                      Ram_Inst_Read,
  input  logic [INST_WIDTH-1:0]     Ram_Inst_In,
  output logic [ADDR_WIDTH-1:0]     PC_Out,
  output logic [OPCODE_WIDTH-1:0]   Opcode,
  output logic [REG_ADDR_WIDTH-1:0] Dest_Reg,
  output logic [REG_ADDR_WIDTH-1:0] Source_Reg1,
  output logic [REG_ADDR_WIDTH-1:0] Source_Reg2,
  output logic                      Illegal_Op,
  output logic                      Halted,
  output logic                      PC_Wrap,
  output logic [15:0]               Inst_Count
);

  // Opcodes with meaning to this stage; MUL is the highest legal code.
  localparam logic [OPCODE_WIDTH-1:0] OP_DONE = '0;
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(7);

  localparam logic [ADDR_WIDTH-1:0] PC_MAX = '1;

  logic [INST_WIDTH-1:0]   fetch_buf;
  logic [INST_WIDTH-1:0]   ir;
  logic [OPCODE_WIDTH-1:0] buf_opcode;
  logic [ADDR_WIDTH-1:0]   jump_target;
  logic                    inc_effective;

  assign buf_opcode  = fetch_buf[INST_WIDTH-1 -: OPCODE_WIDTH];
  assign jump_target = ADDR_WIDTH'(Dest_Reg);

  // An increment only takes effect when neither clear nor jump overrides it.
  assign inc_effective = PC_Inc && !PC_Clr && !PC_Load;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what lets a simultaneous IR_Load and
  // PC_Load jump to the old Dest_Reg, and the IR take the old buffer word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC_Out     <= '0;
      fetch_buf  <= '0;
      ir         <= '0;
      Illegal_Op <= 1'b0;
      Halted     <= 1'b0;
      PC_Wrap    <= 1'b0;
      Inst_Count <= '0;
    end else begin
      // Program counter, priority clear > jump > increment.
      if (PC_Clr) begin
        PC_Out <= '0;
      end else if (PC_Load) begin
        PC_Out <= jump_target;
      end else if (PC_Inc) begin
        PC_Out <= PC_Out + 1'b1;
      end

      if (PC_Clr) begin
        PC_Wrap <= 1'b0;
      end else if (inc_effective && (PC_Out == PC_MAX)) begin
        PC_Wrap <= 1'b1;
      end

      if (Ram_Inst_Read) begin
        fetch_buf <= Ram_Inst_In;
      end

      if (IR_Load) begin
        ir         <= fetch_buf;
        Illegal_Op <= (buf_opcode > OP_MUL);
      end

      // Clear wins over a same-cycle load of DONE.
      if (PC_Clr) begin
        Halted <= 1'b0;
      end else if (IR_Load) begin
        Halted <= (buf_opcode == OP_DONE);
      end

      // Counts every PC_Inc strobe, even one overridden by clear or jump.
      if (PC_Inc && (Inst_Count != 16'hFFFF)) begin
        Inst_Count <= Inst_Count + 16'd1;
      end
    end
  end

  assign Opcode      = ir[INST_WIDTH-1 -: OPCODE_WIDTH];
  assign Dest_Reg    = ir[3*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
  assign Source_Reg1 = ir[2*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
  assign Source_Reg2 = ir[REG_ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        pc_clr, pc_load, pc_inc, ir_load, ram_read;
  logic [15:0] ram_in;
  logic [7:0]  pc_out;
  logic [3:0]  opcode, dest_reg, src1, src2;
  logic        illegal_op, halted, pc_wrap;
  logic [15:0] inst_count;

  int checks   = 0;
  int failures = 0;
  int exp_count;

  fetch_unit dut (
    .Clk           (clk),
    .Reset         (reset),
    .PC_Clr        (pc_clr),
    .PC_Load       (pc_load),
    .PC_Inc        (pc_inc),
    .IR_Load       (ir_load),
    .Ram_Inst_Read (ram_read),
    .Ram_Inst_In   (ram_in),
    .PC_Out        (pc_out),
    .Opcode        (opcode),
    .Dest_Reg      (dest_reg),
    .Source_Reg1   (src1),
    .Source_Reg2   (src2),
    .Illegal_Op    (illegal_op),
    .Halted        (halted),
    .PC_Wrap       (pc_wrap),
    .Inst_Count    (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock edge; inputs are changed and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_clr = 0; pc_load = 0; pc_inc = 0; ir_load = 0; ram_read = 0;
  endtask

  // Fetch a word into the buffer, then move it into the IR.
  task automatic load_ir(input logic [15:0] word);
    idle();
    ram_in = word; ram_read = 1;
    step();
    ram_read = 0; ir_load = 1;
    step();
    ir_load = 0;
  endtask

  initial begin
    idle();
    // Reset with every strobe high.
    reset = 1; ram_in = 16'hFFFF;
    pc_clr = 1; pc_load = 1; pc_inc = 1; ir_load = 1; ram_read = 1;
    #1;
    step();
    reset = 0; idle();
    check("rst_pc",      pc_out,     0);
    check("rst_opcode",  opcode,     0);
    check("rst_halted",  halted,     0);
    check("rst_illegal", illegal_op, 0);
    check("rst_count",   inst_count, 0);
    check("rst_wrap",    pc_wrap,    0);
    exp_count = 0;

    // Basic fetch / decode / increment.
    load_ir(16'h5123);
    check("dec_opcode", opcode,   5);
    check("dec_dest",   dest_reg, 1);
    check("dec_src1",   src1,     2);
    check("dec_src2",   src2,     3);
    check("dec_halt",   halted,   0);
    pc_inc = 1; step(); idle(); exp_count++;
    check("inc_pc",    pc_out,     1);
    check("inc_count", inst_count, exp_count);

    // Jump and increment together for two cycles: jump wins, count still bumps.
    load_ir(16'h3A00);
    pc_load = 1; pc_inc = 1;
    step(); exp_count++;
    check("jmp1_pc",    pc_out,     8'h0A);
    check("jmp1_count", inst_count, exp_count);
    step(); exp_count++;
    check("jmp2_pc",    pc_out,     8'h0A);
    check("jmp2_count", inst_count, exp_count);
    idle();

    // Walk PC to 0xFF, then wrap.
    load_ir(16'h3F00);
    pc_load = 1; step(); idle();
    check("jmp_f_pc", pc_out, 8'h0F);
    pc_inc = 1;
    for (int i = 0; i < 240; i++) begin
      step(); exp_count++;
    end
    idle();
    check("pc_max",     pc_out,  8'hFF);
    check("wrap_early", pc_wrap, 0);
    pc_inc = 1; step(); exp_count++;
    check("wrap_pc",   pc_out,  8'h00);
    check("wrap_set",  pc_wrap, 1);
    step(); exp_count++; idle();
    check("wrap_sticky", pc_wrap,    1);
    check("wrap_pc1",    pc_out,     8'h01);
    check("wrap_count",  inst_count, exp_count);
    pc_clr = 1; step(); idle();
    check("clr_wrap", pc_wrap, 0);
    check("clr_pc",   pc_out,  0);

    // Status flags.
    load_ir(16'h0000);
    check("done_halt",    halted,     1);
    check("done_illegal", illegal_op, 0);
    load_ir(16'h9000);
    check("ill_halt",    halted,     0);
    check("ill_illegal", illegal_op, 1);
    check("ill_opcode",  opcode,     9);
    pc_clr = 1; step(); idle();
    check("clr_keeps_illegal", illegal_op, 1);
    load_ir(16'h7000);
    check("mul_legal", illegal_op, 0);
    load_ir(16'h0000);
    pc_clr = 1; step(); idle();
    check("clr_halt", halted, 0);

    // Simultaneous buffer capture and IR load.
    ram_in = 16'h2111; ram_read = 1; step();
    ram_in = 16'h6222; ir_load = 1; step(); idle();
    check("sim_old_op",   opcode,   2);
    check("sim_old_dest", dest_reg, 1);
    check("sim_old_src2", src2,     1);
    ir_load = 1; step(); idle();
    check("sim_new_op",   opcode,   6);
    check("sim_new_src1", src1,     2);

    // Jump with simultaneous IR load uses the pre-edge Dest_Reg.
    ram_in = 16'h3700; ram_read = 1; step(); idle();
    pc_load = 1; ir_load = 1; step(); idle();
    check("jmp_old_dest", pc_out,   8'h02);
    check("jmp_ir_new",   dest_reg, 7);
    pc_load = 1; step(); idle();
    check("jmp_new_dest", pc_out, 8'h07);

    // Counter saturation.
    pc_inc = 1;
    while (exp_count < 16'hFFFF) begin
      step(); exp_count++;
    end
    check("cnt_full", inst_count, 16'hFFFF);
    step(); step(); idle();
    check("cnt_sat", inst_count, 16'hFFFF);

    // Reset mid-sequence with strobes active.
    ram_in = 16'h9ABC;
    reset = 1; pc_inc = 1; pc_load = 1; ir_load = 1; ram_read = 1;
    step();
    reset = 0; idle();
    check("rst2_pc",      pc_out,     0);
    check("rst2_count",   inst_count, 0);
    check("rst2_opcode",  opcode,     0);
    check("rst2_wrap",    pc_wrap,    0);
    check("rst2_illegal", illegal_op, 0);
    // Buffer was cleared too: loading it gives DONE.
    ir_load = 1; step(); idle();
    check("rst2_buf", opcode, 0);
    check("rst2_buf_halt", halted, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
